// File: rtl/instr_fetch_queue_if.sv
// Fetch-unit bus: instruction-memory request/response, redirect and consumer handshake.
// master = fetch queue, slave = memory/consumer side.
interface instr_fetch_queue_if #(
    parameter int PC_W = 64
);
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            mem_req;
    logic [PC_W-1:0] mem_addr;
    logic            mem_ack;
    logic [31:0]     mem_data;
    logic            instr_valid;
    logic [31:0]     instr;
    logic [PC_W-1:0] instr_pc;
    logic            instr_taken;

    modport master (
        input  redirect, redirect_pc, mem_ack, mem_data, instr_taken,
        output mem_req, mem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output redirect, redirect_pc, mem_ack, mem_data, instr_taken,
        input  mem_req, mem_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: single-outstanding memory fetcher feeding a DEPTH-entry {pc, instr} FIFO.
// States: FETCH | normal fetching;  DROP | discard one in-flight response after a redirect.
module instr_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  start_pc,
    instr_fetch_queue_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic            req_q, req_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [PC_W-1:0] pc_mem   [DEPTH];
    logic [31:0]     data_mem [DEPTH];
    logic            ack, push, pop, flush, head_valid;

    // A strobe with no request outstanding is never a response.
    assign ack        = req_q & bus.mem_ack;
    assign head_valid = (state_q == FETCH) && (count_q != '0);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        count_d    = count_q;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        case (state_q)
            FETCH: begin
                if (bus.redirect) begin
                    flush      = 1'b1;
                    count_d    = '0;
                    fetch_pc_d = bus.redirect_pc;
                    if (req_q && !bus.mem_ack) begin
                        state_d = DROP;
                    end else begin
                        req_d  = 1'b1;
                        addr_d = bus.redirect_pc;
                    end
                end else begin
                    pop = bus.instr_taken & head_valid;
                    if (ack) begin
                        push       = 1'b1;
                        fetch_pc_d = addr_q + PC_W'(4);
                    end
                    count_d = count_q + CW'(push) - CW'(pop);
                    // Issue lookahead: a freed slot is requested on the very next cycle.
                    if (ack || !req_q) begin
                        req_d  = (count_d < DEPTH_C);
                        addr_d = fetch_pc_d;
                    end
                end
            end
            DROP: begin
                if (bus.redirect) fetch_pc_d = bus.redirect_pc;
                if (bus.mem_ack) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_d;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= start_pc;
            addr_q     <= '0;
            req_q      <= 1'b0;
            count_q    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            count_q    <= count_d;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= addr_q;
            data_mem[wr_ptr] <= bus.mem_data;
        end
    end

    assign bus.mem_req     = req_q;
    assign bus.mem_addr    = addr_q;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_valid ? data_mem[rd_ptr] : '0;
    assign bus.instr_pc    = head_valid ? pc_mem[rd_ptr]   : '0;
endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 4, number of buffered instruction entries (power of two, 2..16).
REQ-002 The block SHALL provide parameter PC_W, default 64, program-counter width.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 StartPC  input  PC_W  fetch address loaded on reset.
REQ-006 Redirect  input  1  flush queue and restart fetch at RedirectPC (branch taken).
REQ-007 RedirectPC  input  PC_W  new fetch address, sampled when Redirect=1.
REQ-008 MemReq  output  1  instruction-memory read request.
REQ-009 MemAddr  output  PC_W  read address, valid while MemReq=1.
REQ-010 MemAck  input  1  memory response strobe, one cycle per request.
REQ-011 MemData  input  32  instruction word, valid when MemAck=1.
REQ-012 InstrValid  output  1  head entry available.
REQ-013 Instr  output  32  head instruction word.
REQ-014 InstrPC  output  PC_W  address of head instruction.
REQ-015 InstrTaken  input  1  consumer pops head entry this cycle.

Function
REQ-016 Queue SHALL be a DEPTH-entry FIFO of {PC, instruction}; Instr/InstrPC/InstrValid SHALL be driven from the head entry with no combinational path from MemData.
REQ-017 At most one memory request SHALL be outstanding; MemReq and MemAddr SHALL stay constant from assertion until the cycle MemAck=1.
REQ-018 MemReq SHALL assert in FETCH only when queue occupancy < DEPTH; a new request MAY issue the cycle after an ack.
REQ-019 States: FETCH (normal), DROP (discard one in-flight response after a redirect).
REQ-020 FETCH, MemAck=1: push {MemAddr, MemData}; fetch PC <= MemAddr+4, modulo 2^PC_W (wraps from all-ones-minus-3 to 0); entry visible at InstrValid the following cycle.
REQ-021 InstrTaken with InstrValid=1 SHALL pop one entry; InstrTaken with InstrValid=0 SHALL be ignored.
REQ-022 Simultaneous push and pop SHALL leave occupancy unchanged; push into a full queue SHALL never occur (guaranteed by REQ-018).
REQ-023 Redirect=1 SHALL, at the next edge, empty the queue, set fetch PC to RedirectPC, and ignore InstrTaken and any MemAck that cycle.
REQ-024 Redirect while a request is outstanding and MemAck=0: enter DROP, keep MemReq/MemAddr held at old address until MemAck, discard that data, then return to FETCH and request RedirectPC.
REQ-025 Redirect while in DROP SHALL overwrite the pending restart PC; state remains DROP.
REQ-026 InstrValid SHALL be 0 in DROP and for the cycle after any redirect.
REQ-027 MemAck while MemReq=0 SHALL be ignored.

Reset
REQ-028 Reset=1 SHALL immediately clear queue, InstrValid=0, Instr=0, InstrPC=0, MemReq=0, MemAddr=0, state=FETCH, fetch PC=StartPC.
REQ-029 Reset asserted mid-request SHALL abandon the request; first MemReq after deassertion SHALL carry StartPC on the first edge following release.

Verification
REQ-030 Reset with StartPC=0x100, memory latency 1, InstrTaken=1 always -> MemAddr sequence 0x100,0x104,0x108; Instr/InstrPC stream in order, no drops or duplicates.
REQ-031 InstrTaken=0, DEPTH=4 -> exactly 4 acks accepted, MemReq stays 0 afterwards; one pop -> exactly one new request issued.
REQ-032 Redirect to 0x200 with request to 0x10C outstanding, ack 3 cycles later -> that data discarded, next MemAddr=0x200, first InstrPC=0x200.
REQ-033 Redirect to 0x300 same cycle as MemAck and InstrTaken with queue holding 2 entries -> queue empty, acked word dropped, next MemAddr=0x300.
REQ-034 StartPC=0xFFFF_FFFF_FFFF_FFFC -> second MemAddr=0x0, InstrPC values 0x...FFFC then 0x0.
REQ-035 Reset pulsed mid-request, then released with StartPC=0x40 -> InstrValid=0 during reset, next MemAddr=0x40, stale ack before new MemReq ignored.
